// File: rtl/pc_defnitions.sv
// Shared fetch-side definitions: FSM state encoding, NOP word and PC step helper.
package pc_defnitions;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_slot.sv
// One-entry output register between fetch and decode: flush > load > consume > hold.
module fetch_slot
  import pc_defnitions::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        consume,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] pc_inc
);

  logic        valid_r;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] pc_inc_r;

  // slot contents; pc/instr only change on load so they stay stable under stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r  <= 1'b0;
      pc_r     <= 32'd0;
      instr_r  <= NOP_INSTR;
      pc_inc_r <= PC_STEP;
    end else if (flush) begin
      valid_r  <= 1'b0;
    end else if (load) begin
      valid_r  <= 1'b1;
      pc_r     <= load_pc;
      instr_r  <= load_instr;
      pc_inc_r <= pc_next(load_pc);
    end else if (consume) begin
      valid_r  <= 1'b0;
    end else begin
      valid_r  <= valid_r;
    end
  end

  assign valid  = valid_r;
  assign pc     = pc_r;
  assign instr  = instr_r;
  assign pc_inc = pc_inc_r;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch front end: PC register, single-outstanding imem requests, decode slot.
// Optional FETCH_MISALIGN_CHECK_EN adds if_misaligned and parks fetch on misaligned redirects.
module fetch_unit
  import pc_defnitions::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        takeBranch,
  input  logic [31:0] ex_br_jal_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_inc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        if_misaligned
`endif
);

  fetch_state_t state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  req_pc_r, req_pc_s;
  logic         req_valid_s;
  logic         req_fire_s;
  logic         slot_load_s;
  logic         park_s;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned_r;

  // sticky misalignment flag, re-evaluated on every redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned_r <= 1'b0;
    end else if (takeBranch) begin
      misaligned_r <= |ex_br_jal_addr[1:0];
    end else begin
      misaligned_r <= misaligned_r;
    end
  end

  assign park_s        = misaligned_r;
  assign if_misaligned = misaligned_r;
  assign imem_addr     = pc_r;
`else
  assign park_s    = 1'b0;
  assign imem_addr = {pc_r[31:2], 2'b00};
`endif

  // Issue only when the slot can absorb the response, so a full slot is never overwritten.
  assign req_valid_s    = !rst && (state_r == REQ) && (!if_valid || if_ready) && !park_s;
  assign req_fire_s     = req_valid_s && imem_req_ready;
  assign imem_req_valid = req_valid_s;

  // next-state, PC and slot-load decode; redirect overrides everything else
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    req_pc_s    = req_pc_r;
    slot_load_s = 1'b0;
    if (takeBranch) begin
      pc_s = ex_br_jal_addr;
      case (state_r)
        REQ:        state_s = req_fire_s ? DROP : REQ;
        WAIT, DROP: state_s = imem_rsp_valid ? REQ : DROP;
        default:    state_s = REQ;
      endcase
    end else begin
      case (state_r)
        REQ: begin
          if (req_fire_s) begin
            state_s  = WAIT;
            req_pc_s = pc_r;
          end else begin
            state_s  = REQ;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state_s     = REQ;
            slot_load_s = 1'b1;
            pc_s        = pc_next(req_pc_r);
          end else begin
            state_s     = WAIT;
          end
        end
        DROP: begin
          if (imem_rsp_valid) begin
            state_s = REQ;
          end else begin
            state_s = DROP;
          end
        end
        default: state_s = REQ;
      endcase
    end
  end

  // FSM, PC and in-flight request PC registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= REQ;
      pc_r     <= RESET_PC;
      req_pc_r <= RESET_PC;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      req_pc_r <= req_pc_s;
    end
  end

  fetch_slot u_slot (
    .clk        (clk),
    .rst        (rst),
    .load       (slot_load_s),
    .flush      (takeBranch),
    .consume    (if_valid && if_ready),
    .load_pc    (req_pc_r),
    .load_instr (imem_rsp_data),
    .valid      (if_valid),
    .pc         (if_pc),
    .instr      (if_instr),
    .pc_inc     (if_pc_inc)
  );

endmodule
